// File: rtl/mac_seq.sv
// mac_seq: sequential signed dot product over a dual-port RAM with a valid/ready result.
// Define MAC_SEQ_SAT_EN to saturate the accumulator and report a sticky overflow flag.
module mac_seq #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic              ram_we_a,
  output logic              ram_we_b,
  input  logic [DATA_W-1:0] ram_dout_a,
  input  logic [DATA_W-1:0] ram_dout_b,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              overflow
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t r_state, w_next;
  logic [ADDR_W:0] r_idx, r_len;
  logic r_dv, r_ovf, w_go, w_last, w_sat;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0] r_acc, w_prod_ext, w_acc_next;
  assign w_go = r_state == IDLE && start;
  assign w_last = r_idx + 1'b1 == r_len;
  assign w_prod = $signed(ram_dout_a) * $signed(ram_dout_b);
  assign w_prod_ext = ACC_W'(w_prod);
`ifdef MAC_SEQ_SAT_EN
  logic signed [ACC_W:0] w_sum;
  assign w_sum = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_prod_ext);
  assign w_sat = w_sum[ACC_W] != w_sum[ACC_W-1];
  assign w_acc_next = !w_sat ? w_sum[ACC_W-1:0]
                    : w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
  assign w_sat = 1'b0;
  assign w_acc_next = r_acc + w_prod_ext;
`endif
  always_comb
    w_next = r_state == IDLE  ? (start ? (len == '0 ? DONE : FETCH) : IDLE)
           : r_state == FETCH ? (w_last ? DRAIN : FETCH)
           : r_state == DRAIN ? DONE
           : (result_ready ? IDLE : DONE);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // r_dv marks the cycle in which data for last cycle's FETCH address is on ram_dout
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_idx <= '0;
      r_len <= '0;
      r_dv <= 1'b0;
      r_acc <= '0;
      r_ovf <= 1'b0;
      ram_addr_a <= '0;
      ram_addr_b <= '0;
    end else begin
      r_dv <= r_state == FETCH;
      if (w_go) begin
        r_len <= len;
        r_idx <= '0;
        r_acc <= '0;
        r_ovf <= 1'b0;
        if (len != '0) begin
          ram_addr_a <= base_a;
          ram_addr_b <= base_b;
        end
      end else begin
        if (r_state == FETCH) begin
          r_idx <= r_idx + 1'b1;
          if (!w_last) begin
            ram_addr_a <= ram_addr_a + 1'b1;
            ram_addr_b <= ram_addr_b + 1'b1;
          end
        end
        if (r_dv) begin
          r_acc <= w_acc_next;
          r_ovf <= r_ovf | w_sat;
        end
      end
    end
  assign busy = r_state != IDLE;
  assign result_valid = r_state == DONE;
  assign result = r_acc;
  assign overflow = r_ovf;
  assign ram_we_a = 1'b0;
  assign ram_we_b = 1'b0;
endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: scoreboard bench for mac_seq with a behavioural registered dual-port RAM.
module tb_mac_seq;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, result_ready = 1'b0;
  logic busy, ram_we_a, ram_we_b, result_valid, overflow;
  logic [4:0] base_a = '0, base_b = '0, ram_addr_a, ram_addr_b;
  logic [5:0] len = '0;
  logic [15:0] ram_dout_a, ram_dout_b;
  logic [31:0] result;
  logic signed [15:0] mem_a [32];
  logic signed [15:0] mem_b [32];
  typedef struct {logic [31:0] res; logic ovf;} exp_t;
  exp_t sb[$];
  int vectors = 0, errors = 0;

  mac_seq dut (
    .clk(clk), .rst(rst), .start(start), .base_a(base_a), .base_b(base_b), .len(len),
    .busy(busy), .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
    .ram_dout_a(ram_dout_a), .ram_dout_b(ram_dout_b),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    ram_dout_a <= mem_a[ram_addr_a];
    ram_dout_b <= mem_b[ram_addr_b];
  end

  function automatic exp_t model(input logic [4:0] ba, input logic [4:0] bb, input logic [5:0] l);
    longint acc;
    exp_t e;
    acc = 0;
    e.ovf = 1'b0;
    for (int k = 0; k < int'(l); k++) begin
      acc += longint'(mem_a[5'(int'(ba) + k)]) * longint'(mem_b[5'(int'(bb) + k)]);
`ifdef MAC_SEQ_SAT_EN
      if (acc > 64'sd2147483647) begin acc = 64'sd2147483647; e.ovf = 1'b1; end
      if (acc < -64'sd2147483648) begin acc = -64'sd2147483648; e.ovf = 1'b1; end
`endif
    end
    e.res = acc[31:0];
    return e;
  endfunction

  task automatic init_mem();
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = 16'(i - 10);
      mem_b[i] = 16'(2 * i + 1);
    end
    mem_a[0] = 5; mem_a[1] = 15; mem_a[2] = 25; mem_a[3] = 35;
    mem_b[0] = 3; mem_b[1] = 23; mem_b[2] = 43; mem_b[3] = 63;
  endtask

  task automatic do_run(input logic [4:0] ba, input logic [4:0] bb, input logic [5:0] l, input bit early);
    int cyc;
    exp_t e;
    @(negedge clk);
    base_a = ba; base_b = bb; len = l; start = 1'b1; result_ready = early;
    sb.push_back(model(ba, bb, l));
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!result_valid && cyc < 100) begin
      if (cyc <= int'(l)) begin
        vectors++;
        if (ram_addr_a !== 5'(int'(ba) + cyc - 1) || ram_addr_b !== 5'(int'(bb) + cyc - 1)) begin
          errors++;
          $display("FAIL addr cycle %0d: got a=%0d b=%0d expected a=%0d b=%0d", cyc, ram_addr_a, ram_addr_b,
                   5'(int'(ba) + cyc - 1), 5'(int'(bb) + cyc - 1));
        end
      end
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc != (l == 0 ? 1 : int'(l) + 2)) begin
      errors++;
      $display("FAIL latency len=%0d: valid in cycle %0d expected %0d", l, cyc, (l == 0 ? 1 : int'(l) + 2));
    end
    e = sb.pop_front();
    vectors++;
    if (result !== e.res || overflow !== e.ovf) begin
      errors++;
      $display("FAIL result ba=%0d bb=%0d len=%0d: got %0d ovf=%b expected %0d ovf=%b", ba, bb, l,
               $signed(result), overflow, $signed(e.res), e.ovf);
    end
    if (l != 0) begin
      vectors++;
      if (ram_addr_a !== 5'(int'(ba) + int'(l) - 1) || ram_addr_b !== 5'(int'(bb) + int'(l) - 1)) begin
        errors++;
        $display("FAIL addr hold: got a=%0d b=%0d", ram_addr_a, ram_addr_b);
      end
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    vectors++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL handshake: got busy=%b valid=%b expected 0 0", busy, result_valid);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, result_valid, overflow, ram_we_a, ram_we_b} !== 5'b0 || result !== 32'd0 ||
        ram_addr_a !== 5'd0 || ram_addr_b !== 5'd0) begin
      errors++;
      $display("FAIL reset: got busy=%b valid=%b ovf=%b result=%0d addr=%0d/%0d expected all 0",
               busy, result_valid, overflow, result, ram_addr_a, ram_addr_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    init_mem();
    do_run(5'd0, 5'd0, 6'd4, 1'b0);
  endtask

  task automatic test_wrap();
    do_run(5'd30, 5'd2, 6'd4, 1'b0);
    do_run(5'd31, 5'd31, 6'd1, 1'b0);
  endtask

  task automatic test_len0();
    do_run(5'd3, 5'd7, 6'd0, 1'b0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = -16'sd32768;
      mem_b[i] = -16'sd32768;
    end
    do_run(5'd0, 5'd0, 6'd32, 1'b0);
    init_mem();
    do_run(5'd1, 5'd0, 6'd3, 1'b0);
  endtask

  task automatic test_hold();
    exp_t e;
    int cyc;
    logic [31:0] held;
    @(negedge clk);
    base_a = 5'd4; base_b = 5'd8; len = 6'd3; start = 1'b1;
    sb.push_back(model(5'd4, 5'd8, 6'd3));
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!result_valid && cyc < 100) begin @(negedge clk); cyc++; end
    e = sb.pop_front();
    vectors++;
    if (result !== e.res) begin
      errors++;
      $display("FAIL hold result: got %0d expected %0d", $signed(result), $signed(e.res));
    end
    held = e.res;
    for (int i = 0; i < 5; i++) begin
      base_a = 5'd0; len = 6'd1; start = i[0];
      @(negedge clk);
      vectors++;
      if (result_valid !== 1'b1 || busy !== 1'b1 || result !== held) begin
        errors++;
        $display("FAIL hold cycle %0d: got valid=%b busy=%b result=%0d expected 1 1 %0d", i, result_valid,
                 busy, $signed(result), $signed(held));
      end
    end
    start = 1'b1; result_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; result_ready = 1'b0;
    vectors++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold release: got busy=%b valid=%b expected 0 0", busy, result_valid);
    end
  endtask

  task automatic test_ready_early();
    do_run(5'd5, 5'd9, 6'd6, 1'b1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    base_a = 5'd0; base_b = 5'd0; len = 6'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (ram_addr_a !== 5'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun addr: got a=%0d busy=%b expected 2 1", ram_addr_a, busy);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({busy, result_valid, overflow} !== 3'b0 || result !== 32'd0 || ram_addr_a !== 5'd0 ||
        ram_addr_b !== 5'd0) begin
      errors++;
      $display("FAIL midrun reset: got busy=%b valid=%b ovf=%b result=%0d addr=%0d/%0d expected all 0",
               busy, result_valid, overflow, result, ram_addr_a, ram_addr_b);
    end
    @(negedge clk);
    rst = 1'b0;
    do_run(5'd0, 5'd0, 6'd4, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 32; i++) begin
        mem_a[i] = 16'($urandom);
        mem_b[i] = 16'($urandom);
      end
      do_run(5'($urandom), 5'($urandom), 6'($urandom_range(0, 32)), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_len0();
    test_overflow();
    test_hold();
    test_ready_early();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
